fp_add_sequencer: RTL and testbench



---
 rtl/fp_add_sequencer.sv | 122 ++++++++++++
 tb/tb_fp_add_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: round-robin sequencer for a shared FP add datapath
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid_x/req_ready_x        request handshake, requester x (0/1)
//   req_A_x, req_B_x, req_sub_x    operands and subtract flag
//   pa_number_A/B                  operands to the combinational preadder
//   pa_special_case/result         preadder NaN/Inf/zero short-circuit
//   add_start, add_done, add_result  adder launch pulse and completion
//   rsp_valid/rsp_ready            response handshake
//   rsp_id, rsp_result, rsp_err    owner, result, timeout flag
//   busy                           high whenever not idle
module fp_add_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [31:0] req_A_0,
    input  logic [31:0] req_B_0,
    input  logic        req_sub_0,
    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [31:0] req_A_1,
    input  logic [31:0] req_B_1,
    input  logic        req_sub_1,
    output logic [31:0] pa_number_A,
    output logic [31:0] pa_number_B,
    input  logic        pa_special_case,
    input  logic [31:0] pa_special_result,
    output logic        add_start,
    input  logic        add_done,
    input  logic [31:0] add_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
    state_t state, state_n;
    logic rr, owner, gsel, any, expired;
    logic [31:0] op_a, op_b, sel_a, sel_b;
    logic [TMR_W-1:0] timer;

    assign any     = req_valid_0 | req_valid_1;
    // requester 1 wins when alone or when it holds the round-robin turn
    assign gsel    = req_valid_1 & (~req_valid_0 | rr);
    assign sel_a   = gsel ? req_A_1 : req_A_0;
    // subtraction folds into the operand by flipping B's sign bit
    assign sel_b   = gsel ? {req_B_1[31] ^ req_sub_1, req_B_1[30:0]}
                          : {req_B_0[31] ^ req_sub_0, req_B_0[30:0]};
    assign expired = timer == TMR_W'(TIMEOUT - 1);
    assign pa_number_A = op_a;
    assign pa_number_B = op_b;
    assign rsp_id      = owner;

    always_comb begin
        state_n     = state;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        add_start   = 1'b0;
        rsp_valid   = state == RESP;
        busy        = state != IDLE;
        case (state)
            IDLE: begin
                state_n     = any ? LAUNCH : IDLE;
                req_ready_0 = any & ~gsel;
                req_ready_1 = gsel;
            end
            LAUNCH: begin
                state_n   = pa_special_case ? RESP : WAIT;
                add_start = ~pa_special_case;
            end
            WAIT:    state_n = (add_done | expired) ? RESP : WAIT;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr         <= 1'b0;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            timer      <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && any) begin
                op_a  <= sel_a;
                op_b  <= sel_b;
                owner <= gsel;
                rr    <= ~gsel;
            end
            if (state == LAUNCH) begin
                timer <= '0;
                if (pa_special_case) begin
                    rsp_result <= pa_special_result;
                    rsp_err    <= 1'b0;
                end
            end
            if (state == WAIT) begin
                // completion takes priority over a coincident timeout
                if (add_done) begin
                    rsp_result <= add_result;
                    rsp_err    <= 1'b0;
                end else if (expired) begin
                    rsp_result <= 32'h7FC0_0000;
                    rsp_err    <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: table-driven and randomized check of fp_add_sequencer
module tb_fp_add_sequencer;
    localparam int TIMEOUT = 16;

    logic        clk = 0, rst = 1;
    logic        req_valid_0 = 0, req_ready_0, req_sub_0 = 0;
    logic        req_valid_1 = 0, req_ready_1, req_sub_1 = 0;
    logic [31:0] req_A_0 = 0, req_B_0 = 0, req_A_1 = 0, req_B_1 = 0;
    logic [31:0] pa_number_A, pa_number_B, pa_special_result = 0, add_result = 0, rsp_result;
    logic        pa_special_case = 0, add_start, add_done = 0;
    logic        rsp_valid, rsp_ready = 0, rsp_id, rsp_err, busy;

    int vec = 0, errs = 0;
    logic rr_m = 0;

    fp_add_sequencer #(.TIMEOUT(TIMEOUT), .TMR_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_A_0(req_A_0), .req_B_0(req_B_0), .req_sub_0(req_sub_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_A_1(req_A_1), .req_B_1(req_B_1), .req_sub_1(req_sub_1),
        .pa_number_A(pa_number_A), .pa_number_B(pa_number_B),
        .pa_special_case(pa_special_case), .pa_special_result(pa_special_result),
        .add_start(add_start), .add_done(add_done), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] a, b;
        logic        sub;
        logic        sp;
        logic [31:0] sres;
        int          k;
        logic [31:0] ares;
        int          stall;
        int          lat;
        logic [31:0] res;
        logic        err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // reference: special result after 2 cycles, adder result k+2 cycles after
    // acceptance if it arrives within the wait window, else a timeout NaN
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.sp) begin
            r.lat = 2; r.res = v.sres; r.err = 0;
        end else if (v.k >= 1 && v.k <= TIMEOUT) begin
            r.lat = v.k + 2; r.res = v.ares; r.err = 0;
        end else begin
            r.lat = TIMEOUT + 2; r.res = 32'h7FC0_0000; r.err = 1;
        end
        return r;
    endfunction

    task automatic set_req(input logic id, input logic on, input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (id) begin
            req_valid_1 = on; req_A_1 = a; req_B_1 = b; req_sub_1 = sub;
        end else begin
            req_valid_0 = on; req_A_0 = a; req_B_0 = b; req_sub_0 = sub;
        end
    endtask

    task automatic run_op(input vec_t v);
        int c, lat;
        logic stray, stable;
        logic [31:0] held;
        set_req(v.id, 1, v.a, v.b, v.sub);
        #1;
        chk("ready_granted", v.id ? req_ready_1 : req_ready_0, 1);
        chk("ready_other", v.id ? req_ready_0 : req_ready_1, 0);
        rr_m = ~v.id;
        tick();
        set_req(v.id, 0, 0, 0, 0);
        pa_special_case = v.sp;
        pa_special_result = v.sres;
        #1;
        chk("pa_a", pa_number_A, v.a);
        chk("pa_b", pa_number_B, v.b ^ {v.sub, 31'b0});
        chk("launch_start", add_start, !v.sp);
        c = 1; lat = -1; stray = 0;
        while (c < TIMEOUT + 6) begin
            tick();
            c++;
            pa_special_case = 0;
            add_done = 0;
            if (add_start) stray = 1;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            if (v.k == c - 1) begin
                add_done = 1;
                add_result = v.ares;
            end
        end
        chk("stray_start", stray, 0);
        chk("latency", lat, v.lat);
        chk("rsp_result", rsp_result, v.res);
        chk("rsp_err", rsp_err, v.err);
        chk("rsp_id", rsp_id, v.id);
        if (v.stall > 0) begin
            stable = 1;
            held = rsp_result;
            set_req(~v.id, 1, 32'h1, 32'h2, 0);
            repeat (v.stall) begin
                tick();
                if (!rsp_valid || rsp_result !== held || rsp_id !== v.id || req_ready_0 || req_ready_1) stable = 0;
            end
            chk("stall_stable", stable, 1);
            set_req(~v.id, 0, 0, 0, 0);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("post_hs_valid", rsp_valid, 0);
        chk("post_hs_busy", busy, 0);
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        int last, g;
        logic bad;
        tbl.push_back('{0, 32'h3F80_0000, 32'h4000_0000, 0, 0, 0, 2, 32'h4040_0000, 0, 4, 32'h4040_0000, 0});
        tbl.push_back('{1, 32'h3F80_0000, 32'h4000_0000, 1, 0, 0, 1, 32'hBF80_0000, 0, 3, 32'hBF80_0000, 0});
        tbl.push_back('{0, 32'h7F80_0000, 32'h3F80_0000, 0, 1, 32'h7F80_0000, 1, 0, 0, 2, 32'h7F80_0000, 0});
        tbl.push_back('{1, 32'h4120_0000, 32'h3F80_0000, 0, 0, 0, 0, 0, 0, 18, 32'h7FC0_0000, 1});
        tbl.push_back('{0, 32'h4120_0000, 32'h3F80_0000, 1, 0, 0, 16, 32'h1234_5678, 0, 18, 32'h1234_5678, 0});
        tbl.push_back('{1, 32'h4000_0000, 32'hC000_0000, 0, 0, 0, 5, 32'h0000_0000, 5, 7, 32'h0000_0000, 0});
        tbl.push_back('{0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0, 17, 32'hDEAD_BEEF, 0, 18, 32'h7FC0_0000, 1});

        tick();
        tick();
        rst = 0;
        #1;
        chk("rst_ready0", req_ready_0, 0);
        chk("rst_ready1", req_ready_1, 0);
        chk("rst_start", add_start, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pa_a", pa_number_A, 0);
        chk("rst_pa_b", pa_number_B, 0);
        chk("rst_result", rsp_result, 0);

        foreach (tbl[i]) run_op(tbl[i]);

        repeat (24) begin
            v.id = 1'($urandom_range(0, 1));
            v.a = $urandom; v.b = $urandom; v.sub = 1'($urandom_range(0, 1));
            v.sp = $urandom_range(0, 3) == 0; v.sres = $urandom;
            v.k = $urandom_range(0, TIMEOUT + 2); v.ares = $urandom;
            v.stall = $urandom_range(0, 3);
            run_op(model(v));
        end

        req_valid_0 = 1; req_A_0 = 32'h1; req_B_0 = 32'h2;
        req_valid_1 = 1; req_A_1 = 32'h3; req_B_1 = 32'h4;
        pa_special_case = 1; pa_special_result = 32'h7F80_0000;
        rsp_ready = 1;
        last = -1;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (req_ready_0 && req_ready_1) bad = 1;
            if (rsp_valid && rsp_result !== 32'h7F80_0000) bad = 1;
            if (req_ready_0 || req_ready_1) begin
                g = int'(req_ready_1);
                chk("alt_grant", 32'(g), 32'(rr_m));
                if (last >= 0) chk("alt_spacing", 32'(i - last), 3);
                last = i;
                rr_m = ~req_ready_1;
            end
            tick();
        end
        chk("alt_one_ready", bad, 0);
        req_valid_0 = 0; req_valid_1 = 0;
        repeat (4) tick();
        pa_special_case = 0;
        rsp_ready = 0;
        chk("alt_idle", busy, 0);

        req_valid_0 = 1; req_A_0 = 32'h3F80_0000; req_B_0 = 32'h3F80_0000;
        tick();
        req_valid_0 = 0;
        repeat (4) tick();
        chk("mid_wait_busy", busy, 1);
        rst = 1;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_valid", rsp_valid, 0);
        chk("rst_async_pa", pa_number_A, 0);
        tick();
        rst = 0;
        rr_m = 0;
        bad = 0;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            add_done = 1; add_result = 32'hCAFE_F00D;
            tick();
            if (rsp_valid || add_start || busy) bad = 1;
        end
        add_done = 0;
        chk("post_rst_quiet", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
